// File: rtl/imem_responder.sv
// Instruction-fetch responder: word-addressed store answering one fetch at a time after LATENCY cycles.
// Optional halt_o end-of-test marker detection is enabled by defining IMEM_HALT_DETECT_EN.
module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i
`ifdef IMEM_HALT_DETECT_EN
  ,
  output logic                     halt_o
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        enter_resp;

  logic [31:0] mem [DEPTH];

  logic          req_fire, rsp_fire;
  logic [31:0]   rd_addr, offset;
  logic [IW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   rd_word;

  assign req_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // req_fire can only occur in IDLE or on a RESP handshake, so it overrides the above.
    if (req_fire) begin
      addr_d = req_addr_i;
      if (LATENCY <= 1) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
    end
  end

  // Decode the address being turned into a response this cycle.
  assign rd_addr = (state_q == WAIT) ? addr_q : req_addr_i;
  assign offset  = rd_addr - BASE_ADDR;
  assign rd_idx  = offset[IW+1:2];
  assign rd_err  = (|offset[1:0]) | ({2'b00, offset[31:2]} >= 32'(DEPTH));
  // A preload landing on the same edge as the read is forwarded so it is not lost.
  assign rd_word = (load_we_i && (load_addr_i == rd_idx)) ? load_data_i : mem[rd_idx];

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (enter_resp) begin
      data_d = rd_err ? 32'h0000_0000 : rd_word;
      err_d  = rd_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

`ifdef IMEM_HALT_DETECT_EN
  assign halt_o = rsp_fire & ~err_q & (data_q == 32'hc000_1073);
`endif

endmodule
